// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: elastic DEPTH-stage register for packed control words.
// Each stage carries a valid bit; empty stages always hold NOP_VALUE so a
// consumer that ignores out_valid only ever sees side-effect-free words.
// Backpressure ripples combinationally through the take chain (no skid
// buffer), so bubbles anywhere in the pipe collapse while the head stalls.
module ctrl_pipe_stage #(
  parameter int                 WIDTH     = 32,
  parameter int                 DEPTH     = 1,
  parameter logic [WIDTH-1:0]   NOP_VALUE = {WIDTH{1'b0}},
  localparam int                OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  input  logic [DEPTH-1:0]  flush,
  output logic [OCC_W-1:0]  occupancy
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  logic [DEPTH-1:0] take;
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_data [DEPTH];

  // Take chain, walked from the output side: a stage can load when it is
  // empty or when whatever sits below it is moving on. Flush does not gate
  // this, so an upstream stage still sees its word consumed by a flushed stage.
  always_comb begin
    logic rdy;
    rdy = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      take[i] = ~valid_q[i] | rdy;
      rdy     = take[i];
    end
  end

  assign in_ready = take[0];

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_src_in
        assign src_valid[g] = in_valid;
        assign src_data[g]  = in_data;
      end else begin : g_src_prev
        assign src_valid[g] = valid_q[g-1];
        assign src_data[g]  = data_q[g-1];
      end

      // Stage register: flush beats load, load beats drain, otherwise hold.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q[g] <= 1'b0;
          data_q[g]  <= NOP_VALUE;
        end else if (flush[g]) begin
          valid_q[g] <= 1'b0;
          data_q[g]  <= NOP_VALUE;
        end else if (take[g]) begin
          if (src_valid[g]) begin
            valid_q[g] <= 1'b1;
            data_q[g]  <= src_data[g];
          end else begin
            valid_q[g] <= 1'b0;
            data_q[g]  <= NOP_VALUE;
          end
        end
      end
    end
  endgenerate

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  // Occupancy is a plain popcount of the stage valid bits; it cannot exceed DEPTH.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(valid_q[i]);
    end
  end

endmodule

// File: doc/ctrl_pipe_stage.md
# ctrl_pipe_stage

Parametrised, elastic pipeline register for decoded control bundles travelling between core stages (e.g. decode → execute → memory). It carries a WIDTH-bit control word through DEPTH register stages with a per-stage valid bit, valid/ready backpressure, per-stage flush (bubble insertion) and a programmable bubble/reset value. It replaces fixed-field, always-advancing control latches: fields are packed into one vector by the instantiating stage.

## Interface
- WIDTH, default 32: control word width in bits, 1 or more.
- DEPTH, default 1: number of register stages, 1 or more.
- NOP_VALUE, default {WIDTH{1'b0}}: word that an empty stage holds; loaded on reset, flush and drain. It must encode "no side effects", for example reg_we=0 and dmem write enables=0.
- clk, input, 1: the only clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronised externally.
- in_valid, input, 1: the upstream word is present.
- in_ready, output, 1: stage 0 accepts this cycle.
- in_data, input, WIDTH: upstream control word.
- out_valid, output, 1: the last stage holds a valid word.
- out_ready, input, 1: downstream consumes this cycle.
- out_data, output, WIDTH: contents of the last stage.
- flush, input, DEPTH: bit i kills stage i at the next edge.
- occupancy, output, $clog2(DEPTH+1): number of valid stages.

## Operation
- State per stage i (0 = input side, DEPTH-1 = output side): valid[i] and data[i].
- Downstream ready for stage i:
  - ready_dn[DEPTH-1] = out_ready.
  - ready_dn[i] = take[i+1] for the other stages.
- Stage i takes a new word when take[i] = ~valid[i] | ready_dn[i]. This is combinational and is not qualified by flush.
- in_ready = take[0].
- Source for stage i: in_valid/in_data for stage 0, otherwise valid[i-1]/data[i-1].
- Per-edge update for stage i, in priority order:
  1. flush[i] = 1: valid[i] becomes 0 and data[i] becomes NOP_VALUE. Any word moving into stage i is dropped. The source stage still sees its word consumed.
  2. take[i] = 1 and the source is valid: valid[i] becomes 1 and data[i] takes the source data.
  3. take[i] = 1 and the source is invalid: valid[i] becomes 0 and data[i] becomes NOP_VALUE (drain).
  4. Otherwise, stage is stalled: hold valid[i] and data[i].
- Invariant: valid[i] = 0 implies data[i] = NOP_VALUE. A consumer that ignores out_valid therefore sees only NOP words.
- A flush on stage i does not affect stages above i. The instantiating logic asserts the contiguous younger bits.
- Outputs:
  - out_valid = valid[DEPTH-1].
  - out_data = data[DEPTH-1].
  - occupancy = popcount(valid). All three are combinational from registers only.
- in_ready depends combinationally on out_ready through the take chain. There is no skid buffer.

## Timing
- Reset (rst_n = 0, asynchronous): all valid = 0 and all data = NOP_VALUE.
  - During reset: out_valid = 0, out_data = NOP_VALUE, occupancy = 0.
  - in_ready = 1 during reset, because all stages are empty.
- Reset asserted mid-operation discards all in-flight words immediately, without waiting for a clock edge.
- Latency: a word accepted at edge n appears on out_data after edge n+DEPTH-1, provided no stall occurs. DEPTH=1 gives one-cycle register behaviour.
- Throughput: one word per cycle while out_ready = 1.
- Backpressure:
  - With out_ready = 0, the last stage holds its word if it is valid.
  - Bubbles in earlier stages still collapse, so the pipe absorbs up to DEPTH words before in_ready falls.
- Simultaneous events:
  - Consume and accept in the same cycle is a full-pipe pass-through; occupancy is unchanged.
  - flush[i] together with a stall on stage i: flush wins.
  - flush[DEPTH-1] together with out_ready: the word is presented this cycle, and the stage is empty after the edge.
- Occupancy range is 0..DEPTH. It never wraps or overflows.

## Test plan
- Reset value: WIDTH=8, DEPTH=3, NOP_VALUE=8'h04, with rst_n pulsed low between clock edges. Required: out_data=8'h04, out_valid=0 and occupancy=0 immediately, and in_ready=1.
- Streaming: DEPTH=3, out_ready=1, in_data=8'h10, 8'h11, 8'h12 on consecutive cycles. Required: 8'h10 appears with out_valid=1 after the third edge, then one word per cycle, then 8'h04 with out_valid=0 after the drain.
- Backpressure:
  1. Hold out_ready=0 and push 8'hA1, 8'hA2, 8'hA3, 8'hA4. Required: in_ready=0 after three accepts, occupancy=3, and out_data holds 8'hA1.
  2. Release out_ready. Required: the words come out in order, and 8'hA4 is accepted in the same cycle.
- Flush: with a full pipe of A1/A2/A3 (stage 2/1/0), assert flush=3'b011 for one cycle. Required: occupancy goes 3→1, and stages 0–1 hold 8'h04 with valid=0. Exactly one word, 8'hA1, emerges when out_ready is asserted.
- Flush vs. stall: assert flush[2] with out_ready=0 on a valid last stage. Required: out_valid=0 and out_data=8'h04 after the edge.
- Mid-operation reset and DEPTH=1: assert rst_n=0 with an occupancy-3 pipe; a repeat with DEPTH=1 and WIDTH=1 is also required. Required in both: occupancy=0 immediately, and a one-cycle latency after release.
